// File: rtl/clksw_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clksw_pkg : shared state, divider codes and output decode for clksw_sched
// Revision  : 1.0
// ----------------------------------------------------------------------------
package clksw_pkg;

  typedef enum logic [1:0] {
    S_LS    = 2'd0,
    S_TO_HS = 2'd1,
    S_HS    = 2'd2,
    S_TO_LS = 2'd3
  } state_e;

  localparam logic [1:0] DIV_1   = 2'b00;
  localparam logic [1:0] DIV_2   = 2'b01;
  localparam logic [1:0] DIV_4   = 2'b10;
  localparam logic [1:0] DIV_8   = 2'b11;
  localparam logic [1:0] DIV_RST = DIV_8;

  typedef struct packed {
    logic hsclk_sel;
    logic busy;
    logic hs_active;
  } state_outs_t;

  function automatic state_outs_t state_outs(input state_e s);
    state_outs_t o;
    o.hsclk_sel = (s == S_TO_HS) || (s == S_HS);
    o.busy      = (s == S_TO_HS) || (s == S_TO_LS);
    o.hs_active = (s == S_HS);
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clksw_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clksw_sync : STAGES-deep single-bit synchroniser, async active-low reset to 0
// Revision   : 1.0
// ----------------------------------------------------------------------------
module clksw_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_b,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clksw_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clksw_sched : CPU clock-switch speed-change sequencer (HS/LS select, divider)
//               Optional acknowledge watchdog: define CLKSW_WATCHDOG_EN
// Revision    : 1.0
// ----------------------------------------------------------------------------
module clksw_sched
  import clksw_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DWELL_CYCLES   = 16,
  parameter int DWELL_W        = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_in,
  input  logic       rst_b,
  input  logic       sw_hs_req,
  input  logic [1:0] sw_div_sel,
  input  logic       io_slow_req,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       busy,
  output logic       hs_active,
  output logic       sw_err
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DWELL_CYCLES >= (1 << DWELL_W)) begin : g_bad_dwell
    $error("DWELL_W too narrow for DWELL_CYCLES");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES);

  logic               hs_ack, ls_ack, target_hs;
  logic               wd_timeout, wd_err;
  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_dec;
  logic [1:0]         div_q, div_d;
  state_outs_t        outs_q, outs_d;

  clksw_sync #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk_in (clk_in),
    .rst_b  (rst_b),
    .d_i    (hsclk_selected),
    .q_o    (hs_ack)
  );

  clksw_sync #(.STAGES(SYNC_STAGES)) u_sync_ls (
    .clk_in (clk_in),
    .rst_b  (rst_b),
    .d_i    (lsclk_selected),
    .q_o    (ls_ack)
  );

  assign target_hs = sw_hs_req & ~io_slow_req & ~wd_err;
  assign dwell_dec = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_LS;
      dwell_q <= '0;
      div_q   <= DIV_RST;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      div_q   <= div_d;
      outs_q  <= outs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    div_d   = div_q;
    case (state_q)
      S_LS: begin
        dwell_d = dwell_dec;
        // HS clock is stopped only while LS is acknowledged
        if (ls_ack) div_d = sw_div_sel;
        if (target_hs && (dwell_q == '0) && ls_ack) state_d = S_TO_HS;
      end
      S_TO_HS: begin
        if (hs_ack) begin
          state_d = S_HS;
          dwell_d = DWELL_LOAD;
        end else if (wd_timeout) begin
          state_d = S_TO_LS;
        end
      end
      S_HS: begin
        dwell_d = dwell_dec;
        if (!target_hs && ((dwell_q == '0) || io_slow_req)) state_d = S_TO_LS;
      end
      S_TO_LS: begin
        if (ls_ack) begin
          state_d = S_LS;
          dwell_d = DWELL_LOAD;
        end
      end
      default: state_d = S_LS;
    endcase
  end

  always_comb begin
    outs_d = state_outs(state_d);
  end

`ifdef CLKSW_WATCHDOG_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  logic            waiting;

  assign waiting    = ((state_q == S_TO_HS) && !hs_ack) || ((state_q == S_TO_LS) && !ls_ack);
  assign wd_timeout = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign wd_err     = err_q;

  always_comb begin
    to_d  = '0;
    err_d = err_q | (wd_timeout & waiting);
    // counter saturates once expired so a stuck S_TO_LS keeps reporting
    if (waiting && (state_d == state_q)) to_d = wd_timeout ? to_q : to_q + TO_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
`else
  assign wd_timeout = 1'b0;
  assign wd_err     = 1'b0;
`endif

  assign hsclk_sel      = outs_q.hsclk_sel;
  assign busy           = outs_q.busy;
  assign hs_active      = outs_q.hs_active;
  assign cpuclk_div_sel = div_q;
  assign sw_err         = wd_err;

endmodule
`default_nettype wire

// File: tb/tb_clksw_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_clksw_sched : randomized + directed bench for clksw_sched with cycle model
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_clksw_sched;

  localparam int SS = 2;
  localparam int DW = 16;
  localparam int TO = 255;
  localparam int M_LS = 0, M_TOHS = 1, M_HS = 2, M_TOLS = 3;

  logic       clk_in = 1'b0;
  logic       rst_b, sw_hs_req, io_slow_req;
  logic [1:0] sw_div_sel;
  logic       hsclk_selected, lsclk_selected;
  logic       hsclk_sel, busy, hs_active, sw_err;
  logic [1:0] cpuclk_div_sel;

  logic loop_en, glitch_en, man_hs, man_ls, lb_hs, lb_ls, lb_prev;
  logic chk_en, gap_en, prev_sel, found;
  int   n_chk, n_fail, cyc, last_chg, n_chg;

  assign hsclk_selected = loop_en ? lb_hs : man_hs;
  assign lsclk_selected = loop_en ? lb_ls : man_ls;

  clksw_sched dut (
    .clk_in         (clk_in),
    .rst_b          (rst_b),
    .sw_hs_req      (sw_hs_req),
    .sw_div_sel     (sw_div_sel),
    .io_slow_req    (io_slow_req),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .busy           (busy),
    .hs_active      (hs_active),
    .sw_err         (sw_err)
  );

  always #5 clk_in = ~clk_in;

  // Clock switch stand-in: acks follow the select one cycle later, with optional glitches
  always @(negedge clk_in) begin
    lb_hs = lb_prev;
    lb_ls = ~lb_prev;
    if (glitch_en && ($urandom_range(0, 15) == 0)) begin
      lb_hs = 1'b1;
      lb_ls = 1'b1;
    end
    lb_prev = hsclk_sel;
  end

  // Behavioural model: acks seen SS edges late, mode/dwell/divider from the rules
  int   m_mode, m_dwell, m_to, m_next;
  logic [1:0] m_div;
  logic m_err, a_hs, a_ls, m_want;
  logic hq[$];
  logic lq[$];

  always @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      m_mode = M_LS; m_dwell = 0; m_div = 2'b11; m_err = 1'b0; m_to = 0;
      hq.delete(); lq.delete();
      for (int i = 0; i < SS; i++) begin hq.push_back(1'b0); lq.push_back(1'b0); end
    end else begin
      a_hs = hq.pop_front();
      a_ls = lq.pop_front();
      hq.push_back(hsclk_selected);
      lq.push_back(lsclk_selected);
      m_want = sw_hs_req && !io_slow_req && !m_err;
      m_next = m_mode;
      if (m_mode == M_LS) begin
        if (a_ls) m_div = sw_div_sel;
        if (m_want && m_dwell == 0 && a_ls) m_next = M_TOHS;
        if (m_dwell > 0) m_dwell--;
      end else if (m_mode == M_HS) begin
        if (!m_want && (m_dwell == 0 || io_slow_req)) m_next = M_TOLS;
        if (m_dwell > 0) m_dwell--;
      end else if (m_mode == M_TOHS) begin
        if (a_hs) begin m_next = M_HS; m_dwell = DW; end
`ifdef CLKSW_WATCHDOG_EN
        else begin m_to++; if (m_to >= TO) begin m_err = 1'b1; m_next = M_TOLS; end end
`endif
      end else begin
        if (a_ls) begin m_next = M_LS; m_dwell = DW; end
`ifdef CLKSW_WATCHDOG_EN
        else begin m_to++; if (m_to >= TO) m_err = 1'b1; end
`endif
      end
      if (m_next != m_mode) m_to = 0;
      m_mode = m_next;
    end
  end

  function automatic logic [5:0] model_vec();
    return {(m_mode == M_TOHS || m_mode == M_HS), m_div,
            (m_mode == M_TOHS || m_mode == M_TOLS), (m_mode == M_HS), m_err};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {hsclk_sel, cpuclk_div_sel, busy, hs_active, sw_err};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    cyc++;
    if (chk_en) begin
      chk("model_{sel,div,busy,act,err}", dut_vec(), model_vec());
      if (gap_en && (hsclk_sel !== prev_sel)) begin
        n_chg++;
        if (last_chg >= 0) begin
          n_chk++;
          if (cyc - last_chg < DW) begin
            n_fail++;
            $display("FAIL dwell_gap: got %0d cycles between switches, required >= %0d", cyc - last_chg, DW);
          end
        end
        last_chg = cyc;
      end
    end
    prev_sel = hsclk_sel;
  end

  initial begin
    rst_b = 1'b0; sw_hs_req = 1'b0; io_slow_req = 1'b0; sw_div_sel = 2'b00;
    man_hs = 1'b0; man_ls = 1'b0; loop_en = 1'b0; glitch_en = 1'b0;
    lb_prev = 1'b0; lb_hs = 1'b0; lb_ls = 1'b1; chk_en = 1'b0; gap_en = 1'b0;
    prev_sel = 1'b0; found = 1'b0;
    n_chk = 0; n_fail = 0; cyc = 0; last_chg = -1; n_chg = 0;

    repeat (3) @(negedge clk_in);
    chk_en = 1'b1;
    chk("reset_state", dut_vec(), 6'b011000);
    rst_b = 1'b1;

    // First switch to HS with divider /2
    @(negedge clk_in);
    sw_hs_req = 1'b1; sw_div_sel = 2'b01; man_ls = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("sel_before_ack", {5'd0, hsclk_sel}, 6'd0);
    @(negedge clk_in);
    chk("div_loaded", {4'd0, cpuclk_div_sel}, 6'd1);
    chk("sel_busy_up", {4'd0, hsclk_sel, busy}, 6'b000011);
    man_ls = 1'b0; man_hs = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("hs_active_early", {5'd0, hs_active}, 6'd0);
    @(negedge clk_in);
    chk("hs_active_busy", {4'd0, hs_active, busy}, 6'b000010);

    // Divider change in HS is held off
    sw_div_sel = 2'b10;
    repeat (4) @(negedge clk_in);
    chk("div_held_in_hs", {4'd0, cpuclk_div_sel}, 6'd1);

    // Urgent slow request bypasses dwell
    io_slow_req = 1'b1;
    @(negedge clk_in);
    chk("slow_bypass", {4'd0, hsclk_sel, busy}, 6'b000001);
    man_hs = 1'b0; man_ls = 1'b1;
    repeat (4) @(negedge clk_in);
    chk("div_applied_ls", {4'd0, cpuclk_div_sel}, 6'd2);
    repeat (10) @(negedge clk_in);
    chk("stay_ls_slow", {5'd0, hsclk_sel}, 6'd0);
    io_slow_req = 1'b0;
    @(negedge clk_in);
    chk("dwell_hold_a", {5'd0, hsclk_sel}, 6'd0);
    repeat (4) @(negedge clk_in);
    chk("dwell_hold_b", {5'd0, hsclk_sel}, 6'd0);
    @(negedge clk_in);
    chk("dwell_expired", {5'd0, hsclk_sel}, 6'd1);

    // Randomized traffic with looped-back, occasionally glitching acks
    loop_en = 1'b1; glitch_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 7) == 0)  sw_hs_req   = ~sw_hs_req;
      if ($urandom_range(0, 19) == 0) io_slow_req = ~io_slow_req;
      if ($urandom_range(0, 5) == 0)  sw_div_sel  = 2'($urandom_range(0, 3));
    end

    // Fast toggling request: hysteresis must space the switches
    glitch_en = 1'b0; io_slow_req = 1'b0; gap_en = 1'b1; last_chg = -1; n_chg = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 4 == 0) sw_hs_req = ~sw_hs_req;
      @(negedge clk_in);
    end
    gap_en = 1'b0;
    chk("toggle_switched", {5'd0, (n_chg >= 4)}, 6'd1);

    // Reset asserted during S_TO_HS
    sw_hs_req = 1'b0; found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_in);
      found = !hsclk_sel && !busy;
    end
    chk("reach_ls", {5'd0, found}, 6'd1);
    sw_hs_req = 1'b1; found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_in);
      found = hsclk_sel && busy;
    end
    chk("reach_to_hs", {5'd0, found}, 6'd1);
    #2 rst_b = 1'b0;
    #1 chk("async_reset", dut_vec(), 6'b011000);
    repeat (2) @(negedge clk_in);
    rst_b = 1'b1;

`ifdef CLKSW_WATCHDOG_EN
    loop_en = 1'b0; man_hs = 1'b0; man_ls = 1'b1; sw_hs_req = 1'b1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      found = hsclk_sel;
    end
    chk("wd_start", {5'd0, found}, 6'd1);
    repeat (TO + 2) @(negedge clk_in);
    chk("wd_timeout", {4'd0, sw_err, hsclk_sel}, 6'b000010);
    repeat (40) @(negedge clk_in);
    chk("wd_sticky", {4'd0, sw_err, hsclk_sel}, 6'b000010);
`endif

    repeat (5) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clksw_sched.md
Name: clksw_sched

Overview:
- Speed-change sequencer for the CPU clock switch.
- Decides when the CPU runs from the divided high-speed clock or the low-speed clock, arbitrating between a software speed request and an urgent slow-access request (I/O decode).
- Drives the switch's select and divider inputs and completes the select/acknowledge handshake.
- Changes the divider setting only while the high-speed clock is stopped, so it never glitches the CPU clock.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on the two acknowledge inputs (must be >= 2).
- DWELL_CYCLES, 16, minimum clk_in cycles spent in a settled state before a new switch is started (hysteresis).
- DWELL_W, 5, width of the dwell counter (must hold DWELL_CYCLES).
- TIMEOUT_CYCLES, 255, acknowledge timeout, used only when the optional feature is compiled in.

Ports:
- clk_in  input  1  free-running sequencer clock (high-speed oscillator)
- rst_b  input  1  asynchronous active-low reset
- sw_hs_req  input  1  software requests high-speed operation (level)
- sw_div_sel  input  2  software-requested HS divider: 00=/1, 01=/2, 10=/4, 11=/8
- io_slow_req  input  1  current access needs the low-speed clock (level, urgent)
- hsclk_selected  input  1  switch acknowledge: LS clock stopped (async)
- lsclk_selected  input  1  switch acknowledge: HS clock stopped (async)
- hsclk_sel  output  1  select to the clock switch
- cpuclk_div_sel  output  2  divider select to the clock switch
- busy  output  1  a switch is in progress
- hs_active  output  1  settled in high-speed mode
- sw_err  output  1  sticky acknowledge-timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Clocking and sync:
  - Single clock domain clk_in; all state resets asynchronously on rst_b low.
  - hsclk_selected and lsclk_selected pass through SYNC_STAGES flops, reset value 0 (hs_ack, ls_ack internally).
- Arbitration: target_hs = sw_hs_req & !io_slow_req. io_slow_req always wins.
- State machine, registered, one-hot or binary per shared package:
  - S_LS: hsclk_sel=0.
    - If ls_ack=1, cpuclk_div_sel <= sw_div_sel every cycle. This is the only state where the divider may change.
    - Leave for S_TO_HS when target_hs=1, dwell=0 and ls_ack=1.
  - S_TO_HS: hsclk_sel=1, busy=1.
    - On hs_ack=1: go to S_HS and load dwell with DWELL_CYCLES.
    - No abort. A falling target is serviced after arrival.
  - S_HS: hsclk_sel=1, hs_active=1.
    - Go to S_TO_LS when target_hs=0 and (dwell=0 or io_slow_req=1). io_slow_req bypasses dwell.
    - sw_div_sel changes here are ignored until the next S_LS.
  - S_TO_LS: hsclk_sel=0, busy=1.
    - On ls_ack=1: go to S_LS and load dwell with DWELL_CYCLES.
- Dwell counter:
  - Decrements to 0 in S_LS and S_HS; saturates at 0.
  - Loaded on entry to each settled state.
- Reset values:
  - State S_LS, hsclk_sel=0, cpuclk_div_sel=2'b11 (slowest), busy=0, hs_active=0, sw_err=0.
  - Dwell=0, so the first switch is not delayed.
- Latency: a request in S_LS with dwell=0 raises hsclk_sel on the next clk_in edge. hs_active rises SYNC_STAGES+1 cycles after hsclk_selected rises.
- Simultaneous events:
  - sw_hs_req rising with io_slow_req high: stay LS.
  - Both acks high (transient): only the ack matching the current state is used.
- Outputs are registered; no combinational input-to-output paths.
- Reset mid-switch: returns to S_LS immediately with hsclk_sel=0. The clock switch's own reset restores LS selection.

Optional Feature:
- Macro CLKSW_WATCHDOG_EN.
- When defined:
  - A timeout counter runs in S_TO_HS and S_TO_LS.
  - If no ack arrives within TIMEOUT_CYCLES, sw_err is set (sticky until reset) and the FSM goes to S_TO_LS.
  - A timeout in S_TO_LS holds the FSM there with sw_err=1.
  - While sw_err=1, target_hs is forced 0.
- When undefined: no counter; sw_err is tied to 0; transition states wait indefinitely.

Decomposition:
- Shared package clksw_pkg:
  - state typedef/encodings (S_LS, S_TO_HS, S_HS, S_TO_LS);
  - divider code constants (DIV_1, DIV_2, DIV_4, DIV_8);
  - reset divider constant DIV_RST=DIV_8.
- One sub-module: clksw_sync, a parameterised SYNC_STAGES-deep bit synchroniser with async reset, instantiated twice.

Test Plan:
- Reset, then sw_hs_req=1, sw_div_sel=01, lsclk_selected=1 -> cpuclk_div_sel=01 within 3 cycles; hsclk_sel=1 next cycle.
  - Then drop lsclk_selected and raise hsclk_selected -> hs_active=1 after 3 cycles; busy low.
- In S_HS, change sw_div_sel to 10 -> cpuclk_div_sel stays 01 until the next S_LS with ls_ack=1, then becomes 10.
- In S_HS with dwell=12, assert io_slow_req -> hsclk_sel=0 next cycle.
  - Ack lsclk_selected -> S_LS; sw_hs_req still 1 but no return to HS until io_slow_req=0 and 16 dwell cycles elapse.
- Toggle sw_hs_req every 4 cycles with acks looped back (1-cycle delay) -> at most one switch per 16+handshake cycles; hsclk_sel never toggles within a dwell window.
- Assert rst_b=0 during S_TO_HS -> hsclk_sel=0, cpuclk_div_sel=11, busy=0 asynchronously.
- With CLKSW_WATCHDOG_EN: request HS, never assert hsclk_selected -> after 255 cycles sw_err=1, hsclk_sel=0; further sw_hs_req ignored until reset.
